register_pair_file: RTL and testbench

- Clocked, parametrised successor of the 8-bit double register: PAIRS register pairs of two WIDTH-bit halves (low/high).
- Each pair is writable as a low byte, a high byte or a full 2*WIDTH word.
- Two independent read ports, each returning a byte view and a word view.
- A built-in pair stepper (increment/decrement with wrap flag) serves pointer/counter pairs in the CPU datapath, between the decoder's select lines and the 8/16-bit internal buses.

---
 rtl/register_pair_file.sv | 116 +++++++++++
 tb/tb_register_pair_file.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/register_pair_file.sv
// PAIRS register pairs of two WIDTH-bit halves, writable as low/high byte or full word,
// with two combinational read ports and an increment/decrement pair stepper.
module register_pair_file #(
  parameter int WIDTH  = 8,
  parameter int PAIRS  = 4,
  parameter int ADDR_W = 2,
  parameter int BYPASS = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           wr_mode,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WIDTH-1:0]     wr_byte,
  input  logic [2*WIDTH-1:0]   wr_word,
  input  logic                 step_en,
  input  logic                 step_dec,
  input  logic [ADDR_W-1:0]    step_addr,
  input  logic [1:0]           rd1_mode,
  input  logic [ADDR_W-1:0]    rd1_addr,
  input  logic [1:0]           rd2_mode,
  input  logic [ADDR_W-1:0]    rd2_addr,
  output logic [WIDTH-1:0]     rd1_byte,
  output logic [2*WIDTH-1:0]   rd1_word,
  output logic [WIDTH-1:0]     rd2_byte,
  output logic [2*WIDTH-1:0]   rd2_word,
  output logic                 step_wrap
);

  localparam int W2 = 2 * WIDTH;

  logic [PAIRS-1:0][W2-1:0] pair_q;
  logic [PAIRS-1:0][W2-1:0] pair_d;
  logic [PAIRS-1:0][W2-1:0] rd_src;
  logic                     wrap_d;
  logic                     wr_ok;
  logic                     step_ok;
  logic [W2-1:0]            sel1;
  logic [W2-1:0]            sel2;

  // A write to the same pair as a step wins and suppresses the step entirely.
  assign wr_ok   = (wr_mode != 2'b00) && ({1'b0, wr_addr} < (ADDR_W+1)'(PAIRS));
  assign step_ok = step_en && ({1'b0, step_addr} < (ADDR_W+1)'(PAIRS)) &&
                   !(wr_ok && (step_addr == wr_addr));

  always_comb begin
    pair_d = pair_q;
    wrap_d = 1'b0;
    for (int i = 0; i < PAIRS; i++) begin
      if (wr_ok && (wr_addr == ADDR_W'(i))) begin
        case (wr_mode)
          2'b01:   pair_d[i][WIDTH-1:0]  = wr_byte;
          2'b10:   pair_d[i][W2-1:WIDTH] = wr_byte;
          2'b11:   pair_d[i]             = wr_word;
          default: pair_d[i]             = pair_q[i];
        endcase
      end else if (step_ok && (step_addr == ADDR_W'(i))) begin
        if (step_dec) begin
          pair_d[i] = pair_q[i] - W2'(1);
          wrap_d    = (pair_q[i] == '0);
        end else begin
          pair_d[i] = pair_q[i] + W2'(1);
          wrap_d    = (pair_q[i] == '1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_q    <= '0;
      step_wrap <= 1'b0;
    end else begin
      pair_q    <= pair_d;
      step_wrap <= wrap_d;
    end
  end

  // Bypass forwards the resolved next state, but reset must still force zeros.
  assign rd_src = (BYPASS != 0) ? (rst ? '0 : pair_d) : pair_q;

  function automatic logic [W2-1:0] pick(input logic [PAIRS-1:0][W2-1:0] src,
                                         input logic [ADDR_W-1:0]        addr);
    logic [W2-1:0] v;
    v = '0;
    for (int i = 0; i < PAIRS; i++) begin
      if (addr == ADDR_W'(i)) v = src[i];
    end
    return v;
  endfunction

  assign sel1 = pick(rd_src, rd1_addr);
  assign sel2 = pick(rd_src, rd2_addr);

  always_comb begin
    rd1_byte = '0;
    rd1_word = '0;
    case (rd1_mode)
      2'b01:   rd1_byte = sel1[WIDTH-1:0];
      2'b10:   rd1_byte = sel1[W2-1:WIDTH];
      2'b11:   rd1_word = sel1;
      default: rd1_byte = '0;
    endcase
  end

  always_comb begin
    rd2_byte = '0;
    rd2_word = '0;
    case (rd2_mode)
      2'b01:   rd2_byte = sel2[WIDTH-1:0];
      2'b10:   rd2_byte = sel2[W2-1:WIDTH];
      2'b11:   rd2_word = sel2;
      default: rd2_byte = '0;
    endcase
  end

endmodule

// File: tb/tb_register_pair_file.sv
// Directed bench for register_pair_file: a BYPASS=0 and a BYPASS=1 instance share
// every input so the forwarding difference can be observed in the same cycle.
module tb_register_pair_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wr_mode;
  logic [1:0]  wr_addr;
  logic [7:0]  wr_byte;
  logic [15:0] wr_word;
  logic        step_en;
  logic        step_dec;
  logic [1:0]  step_addr;
  logic [1:0]  rd1_mode, rd2_mode;
  logic [1:0]  rd1_addr, rd2_addr;
  logic [7:0]  rd1_byte, rd2_byte, b_rd1_byte, b_rd2_byte;
  logic [15:0] rd1_word, rd2_word, b_rd1_word, b_rd2_word;
  logic        step_wrap, b_step_wrap;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  register_pair_file #(.WIDTH(8), .PAIRS(4), .ADDR_W(2), .BYPASS(0)) dut (
    .clk(clk), .rst(rst), .wr_mode(wr_mode), .wr_addr(wr_addr), .wr_byte(wr_byte),
    .wr_word(wr_word), .step_en(step_en), .step_dec(step_dec), .step_addr(step_addr),
    .rd1_mode(rd1_mode), .rd1_addr(rd1_addr), .rd2_mode(rd2_mode), .rd2_addr(rd2_addr),
    .rd1_byte(rd1_byte), .rd1_word(rd1_word), .rd2_byte(rd2_byte), .rd2_word(rd2_word),
    .step_wrap(step_wrap)
  );

  register_pair_file #(.WIDTH(8), .PAIRS(4), .ADDR_W(2), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .wr_mode(wr_mode), .wr_addr(wr_addr), .wr_byte(wr_byte),
    .wr_word(wr_word), .step_en(step_en), .step_dec(step_dec), .step_addr(step_addr),
    .rd1_mode(rd1_mode), .rd1_addr(rd1_addr), .rd2_mode(rd2_mode), .rd2_addr(rd2_addr),
    .rd1_byte(b_rd1_byte), .rd1_word(b_rd1_word), .rd2_byte(b_rd2_byte), .rd2_word(b_rd2_word),
    .step_wrap(b_step_wrap)
  );

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Present one write/step for a single edge, then return to idle just after it.
  task automatic applyStimulus(input logic [1:0] wm, input logic [1:0] wa, input logic [7:0] wb,
                               input logic [15:0] ww, input logic se, input logic sd,
                               input logic [1:0] sa);
    wr_mode = wm; wr_addr = wa; wr_byte = wb; wr_word = ww;
    step_en = se; step_dec = sd; step_addr = sa;
    @(posedge clk); #1;
    wr_mode = 2'b00; step_en = 1'b0;
  endtask

  task automatic check_word(input string tag, input logic [1:0] addr, input logic [15:0] exp);
    rd1_mode = 2'b11; rd1_addr = addr;
    #1;
    checkOutput(tag, rd1_word, exp);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    wr_mode = 2'b00; wr_addr = '0; wr_byte = '0; wr_word = '0;
    step_en = 1'b0; step_dec = 1'b0; step_addr = '0;
    rd1_mode = 2'b11; rd1_addr = 2'd0; rd2_mode = 2'b00; rd2_addr = 2'd0;
    #2;
    checkOutput("reset_rd1_word", rd1_word, 16'h0000);
    checkOutput("reset_step_wrap", {15'd0, step_wrap}, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;

    applyStimulus(2'b11, 2'd1, 8'h00, 16'h1234, 1'b0, 1'b0, 2'd0);
    check_word("word_pair1", 2'd1, 16'h1234);
    rd2_mode = 2'b01; rd2_addr = 2'd1; #1;
    checkOutput("rd2_low_pair1", {8'h00, rd2_byte}, 16'h0034);
    checkOutput("rd2_low_word_zero", rd2_word, 16'h0000);
    rd2_mode = 2'b10; #1;
    checkOutput("rd2_high_pair1", {8'h00, rd2_byte}, 16'h0012);
    checkOutput("rd1_word_byte_zero", {8'h00, rd1_byte}, 16'h0000);
    rd2_mode = 2'b00; #1;
    checkOutput("rd2_none_byte", {8'h00, rd2_byte}, 16'h0000);

    applyStimulus(2'b11, 2'd2, 8'h00, 16'h00FF, 1'b0, 1'b0, 2'd0);
    applyStimulus(2'b00, 2'd0, 8'h00, 16'h0000, 1'b1, 1'b0, 2'd2);
    checkOutput("inc_carry_no_wrap", {15'd0, step_wrap}, 16'h0000);
    check_word("inc_carry_pair2", 2'd2, 16'h0100);
    for (int i = 0; i < 3; i++) applyStimulus(2'b00, 2'd0, 8'h00, 16'h0000, 1'b1, 1'b1, 2'd2);
    check_word("dec3_pair2", 2'd2, 16'h00FD);
    checkOutput("dec3_no_wrap", {15'd0, step_wrap}, 16'h0000);

    applyStimulus(2'b11, 2'd0, 8'h00, 16'hFFFF, 1'b0, 1'b0, 2'd0);
    applyStimulus(2'b00, 2'd0, 8'h00, 16'h0000, 1'b1, 1'b0, 2'd0);
    checkOutput("inc_wrap_pulse", {15'd0, step_wrap}, 16'h0001);
    check_word("inc_wrap_pair0", 2'd0, 16'h0000);
    @(posedge clk); #1;
    checkOutput("inc_wrap_drops", {15'd0, step_wrap}, 16'h0000);
    applyStimulus(2'b00, 2'd0, 8'h00, 16'h0000, 1'b1, 1'b1, 2'd0);
    checkOutput("dec_wrap_pulse", {15'd0, step_wrap}, 16'h0001);
    check_word("dec_wrap_pair0", 2'd0, 16'hFFFF);

    applyStimulus(2'b11, 2'd3, 8'h00, 16'h10FF, 1'b0, 1'b0, 2'd0);
    applyStimulus(2'b01, 2'd3, 8'hAA, 16'h0000, 1'b1, 1'b0, 2'd3);
    checkOutput("collide_no_wrap", {15'd0, step_wrap}, 16'h0000);
    check_word("collide_pair3", 2'd3, 16'h10AA);
    applyStimulus(2'b10, 2'd3, 8'h55, 16'h0000, 1'b1, 1'b0, 2'd2);
    check_word("both_commit_pair3", 2'd3, 16'h55AA);
    check_word("both_commit_pair2", 2'd2, 16'h00FE);

    wr_mode = 2'b11; wr_addr = 2'd1; wr_word = 16'hBEEF;
    rd1_mode = 2'b11; rd1_addr = 2'd1;
    #1;
    checkOutput("nobypass_old", rd1_word, 16'h1234);
    checkOutput("bypass_new", b_rd1_word, 16'hBEEF);
    @(posedge clk); #1;
    wr_mode = 2'b00;
    #1;
    checkOutput("nobypass_next", rd1_word, 16'hBEEF);

    applyStimulus(2'b00, 2'd0, 8'h00, 16'h0000, 1'b1, 1'b0, 2'd0);
    checkOutput("pre_reset_wrap", {15'd0, step_wrap}, 16'h0001);
    #2;
    rst = 1'b1;
    wr_mode = 2'b11; wr_addr = 2'd1; wr_word = 16'h5555;
    rd1_mode = 2'b11; rd1_addr = 2'd1;
    #1;
    checkOutput("midreset_wrap", {15'd0, step_wrap}, 16'h0000);
    checkOutput("midreset_rd1", rd1_word, 16'h0000);
    checkOutput("midreset_bypass_rd1", b_rd1_word, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0; wr_mode = 2'b00;
    check_word("post_reset_pair1", 2'd1, 16'h0000);
    check_word("post_reset_pair3", 2'd3, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
